// File: rtl/gpu_vram_loader_m_pkg.sv
// Shared constants for the VRAM loader: register map, CTRL bits, FSM states.
package gpu_vram_loader_m_pkg;

   localparam int LOADER_VRAM_ADDR_WIDTH = 12;
   localparam int LOADER_LEN_WIDTH       = 12;

   localparam logic [2:0] LOADER_REG_SRC_LO = 3'd0;
   localparam logic [2:0] LOADER_REG_SRC_HI = 3'd1;
   localparam logic [2:0] LOADER_REG_DST_LO = 3'd2;
   localparam logic [2:0] LOADER_REG_DST_HI = 3'd3;
   localparam logic [2:0] LOADER_REG_LEN_LO = 3'd4;
   localparam logic [2:0] LOADER_REG_LEN_HI = 3'd5;
   localparam logic [2:0] LOADER_REG_CTRL   = 3'd6;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;
   localparam int CTRL_ACK_BIT   = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_READ  = 3'd2,
      ST_LATCH = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } loaderState_e;

   function automatic logic isBusy(input loaderState_e s);
      return (s inside {ST_WAIT, ST_READ, ST_LATCH, ST_WRITE});
   endfunction

endpackage

// File: rtl/gpu_vram_loader_m_if.sv
// CPU register bus, system-memory read port and VRAM write port of the loader.
interface gpu_vram_loader_m_if #(
   parameter int VRAM_ADDR_WIDTH = 12
);
   logic                       cpu_we;
   logic [2:0]                 cpu_addr;
   logic [7:0]                 cpu_wdata;
   logic [7:0]                 cpu_status;
   logic                       irq;
   logic [15:0]                mem_addr;
   logic                       mem_rd;
   logic [7:0]                 mem_rdata;
   logic                       vblank;
   logic [7:0]                 data;
   logic [VRAM_ADDR_WIDTH-1:0] address;
   logic                       cs;

   modport slave (
      input  cpu_we, cpu_addr, cpu_wdata, mem_rdata, vblank,
      output cpu_status, irq, mem_addr, mem_rd, data, address, cs
   );

   modport master (
      output cpu_we, cpu_addr, cpu_wdata, mem_rdata, vblank,
      input  cpu_status, irq, mem_addr, mem_rd, data, address, cs
   );
endinterface

// File: rtl/gpu_vram_loader_m_regs.sv
// Loader register file: holds programmed src/dst/len and decodes CTRL into
// single-cycle start/abort/ack pulses.
module gpu_vram_loader_regs_m
   import gpu_vram_loader_m_pkg::*;
#(
   parameter int VRAM_ADDR_WIDTH = LOADER_VRAM_ADDR_WIDTH,
   parameter int LEN_WIDTH       = LOADER_LEN_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cpuWe_i,
   input  logic [2:0]                 cpuAddr_i,
   input  logic [7:0]                 cpuWdata_i,
   input  logic                       busy_i,
   output logic [15:0]                src_o,
   output logic [VRAM_ADDR_WIDTH-1:0] dst_o,
   output logic [LEN_WIDTH-1:0]       len_o,
   output logic                       start_o,
   output logic                       abort_o,
   output logic                       ack_o
);

   logic [7:0] srcLo_q, srcHi_q, dstLo_q, lenLo_q;
   logic [3:0] dstHi_q, lenHi_q;
   logic [11:0] dstFull, lenFull;
   logic ctrlWrite;

   // Programmed values are frozen while a transfer is running.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         srcLo_q <= '0;
         srcHi_q <= '0;
         dstLo_q <= '0;
         dstHi_q <= '0;
         lenLo_q <= '0;
         lenHi_q <= '0;
      end else if (cpuWe_i && !busy_i) begin
         case (cpuAddr_i)
            LOADER_REG_SRC_LO: srcLo_q <= cpuWdata_i;
            LOADER_REG_SRC_HI: srcHi_q <= cpuWdata_i;
            LOADER_REG_DST_LO: dstLo_q <= cpuWdata_i;
            LOADER_REG_DST_HI: dstHi_q <= cpuWdata_i[3:0];
            LOADER_REG_LEN_LO: lenLo_q <= cpuWdata_i;
            LOADER_REG_LEN_HI: lenHi_q <= cpuWdata_i[3:0];
            default: ;
         endcase
      end
   end

   assign dstFull = {dstHi_q, dstLo_q};
   assign lenFull = {lenHi_q, lenLo_q};
   assign src_o   = {srcHi_q, srcLo_q};
   assign dst_o   = dstFull[VRAM_ADDR_WIDTH-1:0];
   assign len_o   = lenFull[LEN_WIDTH-1:0];

   // Abort beats a simultaneous start; start is dropped while busy.
   assign ctrlWrite = cpuWe_i && (cpuAddr_i == LOADER_REG_CTRL);
   assign abort_o   = ctrlWrite && cpuWdata_i[CTRL_ABORT_BIT];
   assign start_o   = ctrlWrite && cpuWdata_i[CTRL_START_BIT] && !cpuWdata_i[CTRL_ABORT_BIT] && !busy_i;
   assign ack_o     = ctrlWrite && cpuWdata_i[CTRL_ACK_BIT];

endmodule

// File: rtl/gpu_vram_loader_m.sv
// Copies a byte block from system memory into VRAM, one byte per 3 cycles,
// only starting a byte while vblank is high.
module gpu_vram_loader_m
   import gpu_vram_loader_m_pkg::*;
#(
   parameter int VRAM_ADDR_WIDTH = LOADER_VRAM_ADDR_WIDTH,
   parameter int LEN_WIDTH       = LOADER_LEN_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   gpu_vram_loader_m_if.slave    bus
);

   loaderState_e               state_q;
   logic [15:0]                src_q, memAddr_q, regSrc;
   logic [VRAM_ADDR_WIDTH-1:0] dst_q, address_q, regDst;
   logic [LEN_WIDTH-1:0]       len_q, regLen;
   logic [7:0]                 data_q;
   logic                       memRd_q, cs_q, done_q, irq_q;
   logic                       busy, startPulse, abortPulse, ackPulse;

   assign busy = isBusy(state_q);

   gpu_vram_loader_regs_m #(
      .VRAM_ADDR_WIDTH(VRAM_ADDR_WIDTH),
      .LEN_WIDTH      (LEN_WIDTH)
   ) uRegs (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cpuWe_i   (bus.cpu_we),
      .cpuAddr_i (bus.cpu_addr),
      .cpuWdata_i(bus.cpu_wdata),
      .busy_i    (busy),
      .src_o     (regSrc),
      .dst_o     (regDst),
      .len_o     (regLen),
      .start_o   (startPulse),
      .abort_o   (abortPulse),
      .ack_o     (ackPulse)
   );

   // WRITE chains straight into READ when vblank is still high, giving 3 cycles/byte.
   // Completion is assigned after the ack clear so it wins a same-cycle ack.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         memAddr_q <= '0;
         memRd_q   <= 1'b0;
         data_q    <= '0;
         address_q <= '0;
         cs_q      <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         memRd_q <= 1'b0;
         cs_q    <= 1'b0;
         if (ackPulse) begin
            done_q <= 1'b0;
            irq_q  <= 1'b0;
         end
         if (abortPulse && busy) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  state_q <= ST_IDLE;
                  if (startPulse) begin
                     src_q  <= regSrc;
                     dst_q  <= regDst;
                     len_q  <= regLen;
                     done_q <= 1'b0;
                     irq_q  <= 1'b0;
                     if (regLen == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                     end else begin
                        state_q <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (bus.vblank) begin
                     state_q   <= ST_READ;
                     memRd_q   <= 1'b1;
                     memAddr_q <= src_q;
                  end
               end
               ST_READ: state_q <= ST_LATCH;
               ST_LATCH: begin
                  state_q   <= ST_WRITE;
                  data_q    <= bus.mem_rdata;
                  address_q <= dst_q;
                  cs_q      <= 1'b1;
               end
               ST_WRITE: begin
                  src_q <= src_q + 16'd1;
                  dst_q <= dst_q + VRAM_ADDR_WIDTH'(1);
                  len_q <= len_q - LEN_WIDTH'(1);
                  if (len_q == LEN_WIDTH'(1)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     irq_q   <= 1'b1;
                  end else if (bus.vblank) begin
                     state_q   <= ST_READ;
                     memRd_q   <= 1'b1;
                     memAddr_q <= src_q + 16'd1;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.cpu_status = {6'b0, done_q, busy};
   assign bus.irq        = irq_q;
   assign bus.mem_addr   = memAddr_q;
   assign bus.mem_rd     = memRd_q;
   assign bus.data       = data_q;
   assign bus.address    = address_q;
   assign bus.cs         = cs_q;

endmodule

// File: tb/tb_gpu_vram_loader_m.sv
// Randomized bench for gpu_vram_loader_m: memory image plus queue-based
// model of the expected memory reads and VRAM writes.
module tb_gpu_vram_loader_m;
   import gpu_vram_loader_m_pkg::*;

   localparam int AW = 12;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } vramWrite_t;

   logic clk;
   logic rst_n;

   gpu_vram_loader_m_if #(.VRAM_ADDR_WIDTH(AW)) bus();

   gpu_vram_loader_m #(.VRAM_ADDR_WIDTH(AW), .LEN_WIDTH(12)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int checkCount;
   int failCount;
   logic [7:0] mem [65536];
   vramWrite_t expWrites[$];
   logic [15:0] expReads[$];
   int csCycles[$];
   int csCount = 0;
   int rdCount = 0;
   int cycleCnt = 0;
   logic [3:0] vbHist = 4'b0;
   logic toggleEn;
   logic vblankReq;
   int toggleCnt = 0;
   logic toggleVal = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns data exactly one cycle after mem_rd, junk otherwise
   always @(posedge clk) begin
      if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
      else                     bus.mem_rdata <= 8'($urandom);
   end

   // vblank source: either held at vblankReq or toggled every 5 cycles
   always @(posedge clk) begin
      #2;
      if (toggleEn) begin
         toggleCnt++;
         if (toggleCnt >= 5) begin
            toggleCnt = 0;
            toggleVal = ~toggleVal;
         end
         bus.vblank = toggleVal;
      end else begin
         bus.vblank = vblankReq;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Scoreboard of every memory read and VRAM write
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         cycleCnt++;
         vbHist = {vbHist[2:0], bus.vblank};
         if (bus.mem_rd === 1'b1) begin
            rdCount++;
            if (expReads.size() == 0) checkOutput("unexpected mem_rd", 1, 0);
            else                      checkOutput("mem_addr", bus.mem_addr, expReads.pop_front());
         end
         if (bus.cs === 1'b1) begin
            vramWrite_t e;
            csCount++;
            csCycles.push_back(cycleCnt);
            checkOutput("cs within vblank window", {31'b0, |vbHist[3:1]}, 1);
            if (expWrites.size() == 0) begin
               checkOutput("unexpected cs", 1, 0);
            end else begin
               e = expWrites.pop_front();
               checkOutput("vram address", bus.address, e.addr);
               checkOutput("vram data", bus.data, e.data);
            end
         end
      end
   end

   task automatic pushTransfer(input logic [15:0] src, input logic [11:0] dst, input int len);
      logic [15:0] s;
      vramWrite_t w;
      for (int i = 0; i < len; i++) begin
         s = src + 16'(i);
         expReads.push_back(s);
         w.addr = dst + 12'(i);
         w.data = mem[s];
         expWrites.push_back(w);
      end
   endtask

   task automatic flushModel();
      expReads.delete();
      expWrites.delete();
   endtask

   task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] wdata);
      @(posedge clk); #1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      @(posedge clk); #1;
      bus.cpu_we    = 1'b0;
   endtask

   task automatic programRegs(input logic [15:0] src, input logic [11:0] dst, input logic [11:0] len);
      applyStimulus(LOADER_REG_SRC_LO, src[7:0]);
      applyStimulus(LOADER_REG_SRC_HI, src[15:8]);
      applyStimulus(LOADER_REG_DST_LO, dst[7:0]);
      applyStimulus(LOADER_REG_DST_HI, {4'b0, dst[11:8]});
      applyStimulus(LOADER_REG_LEN_LO, len[7:0]);
      applyStimulus(LOADER_REG_LEN_HI, {4'b0, len[11:8]});
   endtask

   task automatic waitIrq(input int budget, input string tag);
      int n = 0;
      while (bus.irq !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, " irq"}, {31'b0, bus.irq}, 1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " cs"},       {31'b0, bus.cs}, 0);
      checkOutput({tag, " mem_rd"},   {31'b0, bus.mem_rd}, 0);
      checkOutput({tag, " irq"},      {31'b0, bus.irq}, 0);
      checkOutput({tag, " status"},   bus.cpu_status, 0);
      checkOutput({tag, " data"},     bus.data, 0);
      checkOutput({tag, " address"},  bus.address, 0);
      checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int csBase, rdBase, cycBase, n;
      logic [15:0] rs;
      logic [11:0] rdst;

      checkCount    = 0;
      failCount     = 0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 3'd0;
      bus.cpu_wdata = 8'd0;
      toggleEn      = 1'b0;
      vblankReq     = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst_n = 1'b1;

      // Test 1: basic transfer inside vblank
      $display("[TB] test 1: 4 bytes from 0x1000");
      pushTransfer(16'h1000, 12'h000, 4);
      csBase = csCount; cycBase = csCycles.size();
      programRegs(16'h1000, 12'h000, 12'd4);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      waitIrq(100, "t1");
      checkOutput("t1 cs count", csCount - csBase, 4);
      for (int k = 1; k < 4; k++)
         checkOutput("t1 cs spacing", csCycles[cycBase + k] - csCycles[cycBase + k - 1], 3);
      checkOutput("t1 status", bus.cpu_status, 8'h02);
      checkOutput("t1 writes left", expWrites.size(), 0);

      // Test 2: held off by vblank=0
      $display("[TB] test 2: waiting for vblank");
      vblankReq = 1'b0;
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 5);
      csBase = csCount; rdBase = rdCount;
      programRegs(rs, rdst, 12'd5);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t2 status busy", bus.cpu_status, 8'h01);
      checkOutput("t2 no mem_rd", rdCount - rdBase, 0);
      checkOutput("t2 no cs", csCount - csBase, 0);
      vblankReq = 1'b1;
      waitIrq(100, "t2");
      checkOutput("t2 cs count", csCount - csBase, 5);
      checkOutput("t2 writes left", expWrites.size(), 0);

      // Test 3: vblank toggling every 5 cycles
      $display("[TB] test 3: toggling vblank, 16 bytes");
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 16);
      csBase = csCount; rdBase = rdCount;
      programRegs(rs, rdst, 12'd16);
      toggleEn = 1'b1;
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      waitIrq(400, "t3");
      toggleEn = 1'b0;
      checkOutput("t3 cs count", csCount - csBase, 16);
      checkOutput("t3 mem_rd count", rdCount - rdBase, 16);
      checkOutput("t3 writes left", expWrites.size(), 0);

      // Test 4: src and dst wrap
      $display("[TB] test 4: address wrap");
      pushTransfer(16'hFFFF, 12'hFFE, 3);
      csBase = csCount;
      programRegs(16'hFFFF, 12'hFFE, 12'd3);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      waitIrq(100, "t4");
      checkOutput("t4 cs count", csCount - csBase, 3);
      checkOutput("t4 writes left", expWrites.size(), 0);

      // Test 5a: zero length then ack
      $display("[TB] test 5: zero length, abort, busy writes");
      csBase = csCount; rdBase = rdCount;
      programRegs(16'($urandom), 12'($urandom), 12'd0);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      checkOutput("t5 len0 irq", {31'b0, bus.irq}, 1);
      checkOutput("t5 len0 status", bus.cpu_status, 8'h02);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t5 len0 no cs", csCount - csBase, 0);
      checkOutput("t5 len0 no mem_rd", rdCount - rdBase, 0);
      applyStimulus(LOADER_REG_CTRL, 8'h04);
      checkOutput("t5 ack irq", {31'b0, bus.irq}, 0);
      checkOutput("t5 ack status", bus.cpu_status, 8'h00);

      // Test 5b: abort after second byte
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 8);
      csBase = csCount;
      programRegs(rs, rdst, 12'd8);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      n = 0;
      while (csCount - csBase < 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      applyStimulus(LOADER_REG_CTRL, 8'h02);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t5 abort cs count", csCount - csBase, 2);
      checkOutput("t5 abort irq", {31'b0, bus.irq}, 0);
      checkOutput("t5 abort status", bus.cpu_status, 8'h00);
      flushModel();

      // Test 5c: SRC writes during a transfer are ignored
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 8);
      csBase = csCount;
      programRegs(rs, rdst, 12'd8);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      applyStimulus(LOADER_REG_SRC_LO, ~rs[7:0]);
      applyStimulus(LOADER_REG_SRC_HI, ~rs[15:8]);
      waitIrq(100, "t5 busy write");
      checkOutput("t5 busy write cs count", csCount - csBase, 8);
      checkOutput("t5 busy write left", expWrites.size(), 0);
      applyStimulus(LOADER_REG_CTRL, 8'h04);
      pushTransfer(rs, rdst, 8);
      csBase = csCount;
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      waitIrq(100, "t5 restart");
      checkOutput("t5 restart cs count", csCount - csBase, 8);
      checkOutput("t5 restart left", expWrites.size(), 0);

      // Test 6: reset in the middle of a WRITE
      $display("[TB] test 6: reset during write");
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 4);
      programRegs(rs, rdst, 12'd4);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      n = 0;
      while (bus.cs !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("t6 cs seen", {31'b0, bus.cs}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("t6 mid reset");
      flushModel();
      @(negedge clk);
      rst_n = 1'b1;
      rs = 16'($urandom); rdst = 12'($urandom);
      pushTransfer(rs, rdst, 2);
      csBase = csCount;
      programRegs(rs, rdst, 12'd2);
      applyStimulus(LOADER_REG_CTRL, 8'h01);
      waitIrq(100, "t6 recover");
      checkOutput("t6 recover cs count", csCount - csBase, 2);
      applyStimulus(LOADER_REG_CTRL, 8'h04);
      checkOutput("t6 ack irq", {31'b0, bus.irq}, 0);
      checkOutput("t6 ack status", bus.cpu_status, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
